flog_arbiter: RTL

FLOG_ARBITER -- requirements
Module: flog_arbiter

---
 rtl/flog_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/flog_arbiter.sv
// Round-robin arbiter sharing one bfloat16 flog engine among N_REQ requesters.
// Ports: req_* (per-requester operands), eng_* (engine side), resp_* (result out).
module flog_arbiter #(
  parameter int N_REQ   = 4,
  parameter int EXP     = 8,
  parameter int MAN     = 7,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_sign,
  input  logic [N_REQ*EXP-1:0]    req_exponent,
  input  logic [N_REQ*MAN-1:0]    req_fractional,
  output logic                    eng_sign,
  output logic [EXP-1:0]          eng_exponent,
  output logic [MAN-1:0]          eng_fractional,
  output logic                    eng_valid,
  input  logic                    eng_s_res,
  input  logic [EXP-1:0]          eng_e_res,
  input  logic [MAN-1:0]          eng_f_res,
  input  logic                    eng_valid_o,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic                    resp_sign,
  output logic [EXP-1:0]          resp_exponent,
  output logic [MAN-1:0]          resp_fractional,
  output logic                    resp_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  gid_q, gid_d;
  logic           op_s_q, op_s_d;
  logic [EXP-1:0] op_e_q, op_e_d;
  logic [MAN-1:0] op_f_q, op_f_d;
  logic           res_s_q, res_s_d;
  logic [EXP-1:0] res_e_q, res_e_d;
  logic [MAN-1:0] res_f_q, res_f_d;
  logic           tmo_q, tmo_d;

  logic           gnt_found;
  logic [IW-1:0]  gnt_idx;
  int             gnt_pos;

  // Search starts one past the last served requester and wraps.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_pos   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      gnt_pos = (int'(last_q) + k) % N_REQ;
      if (!gnt_found && req_valid[gnt_pos]) begin
        gnt_found = 1'b1;
        gnt_idx   = gnt_pos[IW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == S_IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    last_d  = last_q;
    gid_d   = gid_q;
    op_s_d  = op_s_q;
    op_e_d  = op_e_q;
    op_f_d  = op_f_q;
    res_s_d = res_s_q;
    res_e_d = res_e_q;
    res_f_d = res_f_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          gid_d   = gnt_idx;
          op_s_d  = req_sign[gnt_idx];
          op_e_d  = req_exponent[int'(gnt_idx)*EXP +: EXP];
          op_f_d  = req_fractional[int'(gnt_idx)*MAN +: MAN];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the expiry cycle still counts as normal.
        if (eng_valid_o) begin
          res_s_d = eng_s_res;
          res_e_d = eng_e_res;
          res_f_d = eng_f_res;
          tmo_d   = 1'b0;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_s_d = 1'b0;
          res_e_d = '0;
          res_f_d = '0;
          tmo_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          last_d  = gid_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      gid_q   <= '0;
      op_s_q  <= 1'b0;
      op_e_q  <= '0;
      op_f_q  <= '0;
      res_s_q <= 1'b0;
      res_e_q <= '0;
      res_f_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      op_s_q  <= op_s_d;
      op_e_q  <= op_e_d;
      op_f_q  <= op_f_d;
      res_s_q <= res_s_d;
      res_e_q <= res_e_d;
      res_f_q <= res_f_d;
      tmo_q   <= tmo_d;
    end
  end

  assign eng_sign        = op_s_q;
  assign eng_exponent    = op_e_q;
  assign eng_fractional  = op_f_q;
  assign eng_valid       = !rst && state_q == S_ISSUE;
  assign resp_valid      = !rst && state_q == S_RESP;
  assign resp_id         = gid_q;
  assign resp_sign       = res_s_q;
  assign resp_exponent   = res_e_q;
  assign resp_fractional = res_f_q;
  assign resp_timeout    = tmo_q;

endmodule
